// File: rtl/hamming74_encoder_tx.sv
// Hamming(7,4) encoder with input FIFO, optional single-bit error injection and
// serial transmit, position 1 first. The loaded codeword is also held on code_out.
module hamming74_encoder_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:3]       in_data,
  input  logic [2:0]       inj_pos,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_sof,
  output logic [0:6]       code_out,
  output logic [CNT_W-1:0] level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [0:6]       sh_q, sh_d;
  logic [0:6]       code_q, code_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // Each entry is {d1..d4, inj_pos}; d1 sits in the MSB.
  logic [6:0] mem_q [FIFO_DEPTH];

  logic       full;
  logic       push;
  logic       pop;
  logic [6:0] rd_entry;
  logic [0:3] pop_data;
  logic [2:0] pop_inj;
  logic [0:6] clean_code;
  logic [0:6] inj_mask;
  logic [0:6] enc_code;

  assign full     = (level_q == CNT_W'(FIFO_DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (level_q != '0) && ((state_q == IDLE) || (bcnt_q == 3'd6));

  assign rd_entry = mem_q[rd_ptr_q];
  assign pop_data = rd_entry[6:3];
  assign pop_inj  = rd_entry[2:0];

  // Layout p1 p2 d1 p4 d2 d3 d4.
  assign clean_code = {pop_data[0] ^ pop_data[1] ^ pop_data[3],
                       pop_data[0] ^ pop_data[2] ^ pop_data[3],
                       pop_data[0],
                       pop_data[1] ^ pop_data[2] ^ pop_data[3],
                       pop_data[1],
                       pop_data[2],
                       pop_data[3]};

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_inj
      assign inj_mask[gi] = (pop_inj == 3'(gi + 1));
    end
  endgenerate

  assign enc_code = clean_code ^ inj_mask;

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    sh_d     = sh_q;
    code_d   = code_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + CNT_W'(push) - CNT_W'(pop);

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = SHIFT;
          bcnt_d  = 3'd0;
          sh_d    = enc_code;
          code_d  = enc_code;
        end
      end
      SHIFT: begin
        if (bcnt_q != 3'd6) begin
          sh_d   = {sh_q[1:6], 1'b0};
          bcnt_d = bcnt_q + 3'd1;
        end else if (pop) begin
          bcnt_d = 3'd0;
          sh_d   = enc_code;
          code_d = enc_code;
        end else begin
          state_d = IDLE;
          bcnt_d  = 3'd0;
        end
      end
      default: begin
        state_d = IDLE;
        bcnt_d  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bcnt_q   <= 3'd0;
      sh_q     <= '0;
      code_q   <= '0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      sh_q     <= sh_d;
      code_q   <= code_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_data, inj_pos};
  end

  assign ser_valid = (state_q == SHIFT);
  assign ser_sof   = ser_valid && (bcnt_q == 3'd0);
  assign ser_out   = ser_valid && sh_q[0];
  assign code_out  = code_q;
  assign level     = level_q;

endmodule

// File: tb/tb_hamming74_encoder_tx.sv
// Directed bench for hamming74_encoder_tx: single words, full sweep, back-pressure,
// simultaneous push/pop and reset in the middle of a codeword.
module tb_hamming74_encoder_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [0:3] in_data;
  logic [2:0] inj_pos;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_sof;
  logic [0:6] code_out;
  logic [2:0] level;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] exp_w [8];
  logic [3:0] nib_w [8];
  logic [2:0] inj_w [8];

  hamming74_encoder_tx #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .inj_pos  (inj_pos),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_sof  (ser_sof),
    .code_out (code_out),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: classic position-indexed Hamming, parity k covers positions with bit k set.
  function automatic logic [6:0] ref_code(input logic [3:0] d, input logic [2:0] inj);
    logic [7:1] pos;
    logic [6:0] r;
    pos = '0;
    pos[3] = d[3]; pos[5] = d[2]; pos[6] = d[1]; pos[7] = d[0];
    for (int p = 3; p <= 7; p++) begin
      if (p != 4) begin
        if (p[0]) pos[1] = pos[1] ^ pos[p];
        if (p[1]) pos[2] = pos[2] ^ pos[p];
        if (p[2]) pos[4] = pos[4] ^ pos[p];
      end
    end
    if (inj != 3'd0) pos[inj] = ~pos[inj];
    for (int p = 1; p <= 7; p++) r[7 - p] = pos[p];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one word into an idle, empty block and follow its codeword out.
  task automatic send_and_check(input logic [3:0] nib, input logic [2:0] inj, input logic [6:0] exp);
    in_valid = 1'b1;
    in_data  = nib;
    inj_pos  = inj;
    tick();
    in_valid = 1'b0;
    check_val("acc_level", level, 1);
    check_val("acc_no_valid", ser_valid, 0);
    tick();
    check_val("code_out", code_out, exp);
    for (int i = 0; i < 7; i++) begin
      check_val("bit_valid", ser_valid, 1);
      check_val("bit_sof", ser_sof, (i == 0));
      check_val("bit_out", ser_out, exp[6 - i]);
      tick();
    end
    check_val("end_valid", ser_valid, 0);
    check_val("end_level", level, 0);
    $display("tx d=%b inj=%0d code=%b", nib, inj, exp);
  endtask

  // Expect nw contiguous codewords from exp_w[0..nw-1].
  task automatic consume(input int nw);
    int guard = 0;
    while (!ser_valid && guard < 30) begin
      tick();
      guard++;
    end
    check_val("stream_start", ser_valid, 1);
    for (int k = 0; k < 7 * nw; k++) begin
      int w = k / 7;
      int b = k % 7;
      check_val("stream_valid", ser_valid, 1);
      check_val("stream_sof", ser_sof, (b == 0));
      check_val("stream_bit", ser_out, exp_w[w][6 - b]);
      if (b == 0) begin
        check_val("stream_code", code_out, exp_w[w]);
        $display("rx word %0d code=%b", w, exp_w[w]);
      end
      tick();
    end
    check_val("stream_end", ser_valid, 0);
  endtask

  task automatic push_now(input int w);
    in_valid = 1'b1;
    in_data  = nib_w[w];
    inj_pos  = inj_w[w];
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_full;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    inj_pos  = '0;
    repeat (3) tick();
    check_val("rst_valid", ser_valid, 0);
    check_val("rst_sof", ser_sof, 0);
    check_val("rst_out", ser_out, 0);
    check_val("rst_code", code_out, 7'b0000000);
    check_val("rst_level", level, 0);
    check_val("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Hand-computed codewords.
    send_and_check(4'b1111, 3'd0, 7'b1111111);
    send_and_check(4'b1111, 3'd1, 7'b0111111);
    send_and_check(4'b1011, 3'd0, 7'b0110011);
    send_and_check(4'b0001, 3'd7, 7'b1101000);
    send_and_check(4'b1000, 3'd4, 7'b1111000);

    // Sweep all nibbles against every injection position.
    for (int inj = 0; inj < 8; inj++)
      for (int n = 0; n < 16; n++)
        send_and_check(4'(n), 3'(inj), ref_code(4'(n), 3'(inj)));

    // Back-pressure with six words held on in_valid.
    nib_w = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h9, 4'h6, 4'h0, 4'h0};
    inj_w = '{3'd0, 3'd3, 3'd0, 3'd7, 3'd0, 3'd5, 3'd0, 3'd0};
    for (int w = 0; w < 8; w++) exp_w[w] = ref_code(nib_w[w], inj_w[w]);
    saw_full = 1'b0;
    fork
      begin
        for (int w = 0; w < 6; w++) begin
          logic acc;
          int   guard;
          acc   = 1'b0;
          guard = 0;
          in_valid = 1'b1;
          in_data  = nib_w[w];
          inj_pos  = inj_w[w];
          while (!acc && guard < 50) begin
            if (!in_ready) begin
              saw_full = 1'b1;
              check_val("full_level", level, 4);
            end
            acc = in_ready;
            tick();
            guard++;
          end
          check_val("bp_accepted", acc, 1);
        end
        in_valid = 1'b0;
      end
      consume(6);
    join
    check_val("bp_saw_full", saw_full, 1);
    tick();
    check_val("bp_level_end", level, 0);
    check_val("bp_idle_end", ser_valid, 0);

    // Push on the same edge as the bcnt=6 pop with two words queued.
    nib_w = '{4'h3, 4'hA, 4'h5, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0};
    inj_w = '{3'd0, 3'd2, 3'd0, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0};
    for (int w = 0; w < 8; w++) exp_w[w] = ref_code(nib_w[w], inj_w[w]);
    fork
      begin
        for (int w = 0; w < 3; w++) push_now(w);
        check_val("pp_level_q2", level, 2);
        repeat (5) tick();
        check_val("pp_level_pre", level, 2);
        push_now(3);
        check_val("pp_level_post", level, 2);
      end
      consume(4);
    join
    tick();
    check_val("pp_level_end", level, 0);

    // Reset while bit 3 of a codeword is on the line with two words queued.
    for (int w = 0; w < 3; w++) push_now(w);
    repeat (2) tick();
    check_val("mr_level_pre", level, 2);
    check_val("mr_valid_pre", ser_valid, 1);
    rst_n = 1'b0;
    #1;
    check_val("mr_valid", ser_valid, 0);
    check_val("mr_sof", ser_sof, 0);
    check_val("mr_code", code_out, 7'b0000000);
    check_val("mr_level", level, 0);
    check_val("mr_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("mr_idle", ser_valid, 0);
    send_and_check(4'b1011, 3'd0, 7'b0110011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hamming74_encoder_tx.md
# hamming74_encoder_tx

Hamming(7,4) encoder and serial transmitter. It is the transmit-side counterpart of the team's Hamming(7,4) error-correcting decoder. Nibbles arrive over a valid/ready handshake and are buffered in a small FIFO. Each nibble is encoded into a 7-bit codeword, optionally with one deliberate bit-flip for exercising the decoder, and shifted out serially one bit per clock. The last loaded codeword is also presented in parallel for direct connection to the decoder's 7-bit input.

## Interface

Parameters:
- FIFO_DEPTH, 4: input FIFO entries; power of two, minimum 2.
- CNT_W, 3: width of `level`; must equal clog2(FIFO_DEPTH)+1.

Ports (clock and reset first):
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  `in_data`/`inj_pos` valid this cycle.
- in_ready  output  1  FIFO can accept a word; equals !full.
- in_data  input  [0:3]  data nibble d1..d4 (index 0 = d1).
- inj_pos  input  [2:0]  error injection: 0 = none; 1..7 = invert that codeword position.
- ser_out  output  1  serial codeword bit.
- ser_valid  output  1  `ser_out` carries a codeword bit.
- ser_sof  output  1  high on the first bit (position 1) of each codeword.
- code_out  output  [0:6]  last loaded codeword (after injection); index 0 = position 1.
- level  output  [CNT_W-1:0]  FIFO occupancy.

## Operation

- Handshake: a word is accepted on a rising edge where `in_valid && in_ready`. `{in_data, inj_pos}` are stored together in the FIFO.
- Codeword layout, positions 1..7 = code[0..6]: p1 p2 d1 p4 d2 d3 d4.
  - p1 = d1^d2^d4
  - p2 = d1^d3^d4
  - p4 = d2^d3^d4
- Injection: if `inj_pos` = k with k in 1..7, code[k-1] is inverted after encoding. It is applied at pop time using the stored `inj_pos`.
- FSM states: IDLE, SHIFT. A 3-bit bit counter `bcnt` runs 0..6.
  - IDLE with level>0: pop the FIFO, encode, load the shift register and `code_out`, set bcnt=0, go to SHIFT.
  - IDLE with level=0: remain in IDLE.
  - SHIFT with bcnt<6: shift one bit and increment bcnt.
  - SHIFT with bcnt=6 and level>0: pop and reload, bcnt=0, stay in SHIFT. Back-to-back codewords have no gap.
  - SHIFT with bcnt=6 and level=0: go to IDLE.
- Serial order: position 1 first. `ser_out` = code[bcnt] of the loaded word. `ser_valid` = (state==SHIFT). `ser_sof` = SHIFT && bcnt==0.
- FIFO behaviour:
  - Push and pop in the same cycle leave `level` unchanged.
  - A push into an empty FIFO is not poppable until the next edge; there is no fall-through.
  - Pointers wrap modulo FIFO_DEPTH.
- No overflow is possible: `in_ready` is low when level==FIFO_DEPTH, and any `in_valid` in that state is ignored.
- Underflow is impossible, because pops occur only when level>0.

## Timing

- Reset values (while rst_n is low, asynchronously):
  - state=IDLE, bcnt=0
  - ser_out=0, ser_valid=0, ser_sof=0
  - code_out=7'b0000000
  - level=0, in_ready=1
  - FIFO pointers 0
- Latency: a word accepted at edge t into an empty, IDLE block is popped at edge t+1. `ser_sof`/`ser_valid` rise after edge t+1, and the 7 bits occupy cycles t+1..t+7 (edge-relative).
- Throughput: one codeword per 7 cycles. `ser_valid` stays continuously high while the FIFO is refilled in time.
- All outputs are registered or decoded from registered state. There is no combinational path from `in_valid` to any output.
- `in_ready` is derived from registered `level` only.
- Reset mid-codeword: the partial codeword is abandoned, `ser_valid` drops immediately, and FIFO contents are discarded. The first edge after rst_n rises starts clean in IDLE.

## Test plan

- Encode clean: push in_data=1111, inj_pos=0. Required: code_out=1111111 and ser_out=1,1,1,1,1,1,1 with ser_sof on the first bit only.
- Injection to decoder: push 1111 with inj_pos=1. Required: code_out=0111111, and the serial stream begins with 0. Feeding this to the decoder returns d_disp=1111.
- Mixed value: push 1011 with inj_pos=0. Required: code_out=0110011 and serial sequence 0,1,1,0,0,1,1. Also sweep all 16 nibbles with inj_pos=0, and with inj_pos 1..7, against a reference model.
- Back-pressure and back-to-back, FIFO_DEPTH=4: hold in_valid high for 6 distinct words. Required:
  - in_ready deasserts when level=4.
  - 42 contiguous ser_valid cycles.
  - ser_sof every 7 cycles.
  - Words emerge in push order.
  - level returns to 0 and the FSM is back in IDLE.
- Simultaneous push/pop: push a new word on the same edge as a bcnt=6 pop with level=2. Required: level stays 2 and there is no lost or duplicated word.
- Reset mid-shift: assert rst_n low at bcnt=3 with 2 words queued. Required:
  - ser_valid=0 and code_out=0000000 immediately; level=0 and in_ready=1.
  - After release, a new push is transmitted with correct latency.
